// File: rtl/spi_pkg.sv
// spi_pkg: shared types and helpers for the SPI transfer queue.
//   xfer_state_t : sequencer states (IDLE, LAUNCH, WAIT_DONE, GAP)
//   lvl_width()  : width of a FIFO level/pointer for a given depth
//                  (address bits plus one wrap bit)
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_DONE = 2'd2,
    GAP       = 2'd3
  } xfer_state_t;

  function automatic int lvl_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/spi_xfer_queue_if.sv
// spi_xfer_queue_if: the two valid/ready streams of the transfer queue.
//   tx_valid/tx_ready/tx_data : outbound words, producer -> queue
//   rx_valid/rx_ready/rx_data : received words, queue -> consumer
// Modports: master = software/DMA side, slave = spi_xfer_queue side.
interface spi_xfer_queue_if #(
  parameter int DATA_WIDTH = 32
) ();

  logic                  tx_valid;
  logic                  tx_ready;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  rx_valid;
  logic                  rx_ready;
  logic [DATA_WIDTH-1:0] rx_data;

  modport master (
    output tx_valid, tx_data, rx_ready,
    input  tx_ready, rx_valid, rx_data
  );

  modport slave (
    input  tx_valid, tx_data, rx_ready,
    output tx_ready, rx_valid, rx_data
  );

endinterface

// File: rtl/spi_sync_fifo.sv
// spi_sync_fifo: synchronous first-word-fall-through FIFO.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : synchronous empty; push/pop in the same cycle are ignored
//   push, din  : write request and data (ignored when full)
//   pop        : read request (ignored when empty)
//   dout       : head word, valid whenever empty is low
//   full, empty, level : status derived from the wrap-bit pointers
module spi_sync_fifo
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 64
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             clear,
  input  logic                             push,
  input  logic                             pop,
  input  logic [DATA_WIDTH-1:0]            din,
  output logic [DATA_WIDTH-1:0]            dout,
  output logic                             full,
  output logic                             empty,
  output logic [lvl_width(FIFO_DEPTH)-1:0] level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = lvl_width(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem_r [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_r;
  logic [PW-1:0]         rd_ptr_r;
  logic                  wr_en_s;
  logic                  rd_en_s;

  // Same address with opposite wrap bits means the writer lapped the reader.
  assign full    = (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]) && (wr_ptr_r[AW] != rd_ptr_r[AW]);
  assign empty   = (wr_ptr_r == rd_ptr_r);
  assign level   = wr_ptr_r - rd_ptr_r;
  assign dout    = mem_r[rd_ptr_r[AW-1:0]];
  assign wr_en_s = push && !full && !clear;
  assign rd_en_s = pop && !empty && !clear;

  // Pointer update; clear takes priority over any push or pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else if (clear) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (wr_en_s) wr_ptr_r <= wr_ptr_r + PW'(1);
      if (rd_en_s) rd_ptr_r <= rd_ptr_r + PW'(1);
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (wr_en_s) mem_r[wr_ptr_r[AW-1:0]] <= din;
  end

endmodule

// File: rtl/spi_xfer_queue.sv
// spi_xfer_queue: buffers outbound words and drives the SPI master core's
// start/busy/done handshake, one transfer per word, collecting results.
//   clk, rst_n         : clock, asynchronous active-low reset
//   enable             : permit new launches (in-flight word always finishes)
//   flush              : synchronous clear of both FIFOs and timeout_err
//   stream             : tx/rx valid/ready streams (slave modport)
//   tx_level, rx_level : FIFO occupancies
//   m_start, m_tx_data : launch pulse and word to the master core
//   m_busy, m_done, m_rx_data : master status and received word
//   word_done          : one pulse per word stored in the RX FIFO
//   timeout_err        : sticky abort flag, cleared by flush
module spi_xfer_queue
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int FIFO_DEPTH     = 64,
  parameter int GAP_CYCLES     = 0,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             enable,
  input  logic                             flush,
  spi_xfer_queue_if.slave                  stream,
  output logic [lvl_width(FIFO_DEPTH)-1:0] tx_level,
  output logic [lvl_width(FIFO_DEPTH)-1:0] rx_level,
  output logic                             m_start,
  output logic [DATA_WIDTH-1:0]            m_tx_data,
  input  logic                             m_busy,
  input  logic                             m_done,
  input  logic [DATA_WIDTH-1:0]            m_rx_data,
  output logic                             word_done,
  output logic                             timeout_err
);

  // A zero gap still spends one cycle in GAP.
  localparam int GAP_LEN = (GAP_CYCLES > 0) ? GAP_CYCLES : 1;
  localparam int GW      = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;
  localparam int TW      = $clog2(TIMEOUT_CYCLES);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_LEN - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

  xfer_state_t           state_r, state_s;
  logic [TW-1:0]         to_cnt_r;
  logic [GW-1:0]         gap_cnt_r;
  logic                  discard_r;
  logic                  m_start_r;
  logic [DATA_WIDTH-1:0] m_tx_data_r;
  logic                  word_done_r;
  logic                  timeout_err_r;

  logic                  tx_full_s, tx_empty_s, rx_full_s, rx_empty_s;
  logic [DATA_WIDTH-1:0] tx_dout_s, rx_dout_s;
  logic                  tx_push_s, rx_push_s, rx_pop_s;
  logic                  launch_s, timeout_s;

  assign stream.tx_ready = !tx_full_s;
  assign stream.rx_valid = !rx_empty_s;
  assign stream.rx_data  = rx_dout_s;
  assign m_start         = m_start_r;
  assign m_tx_data       = m_tx_data_r;
  assign word_done       = word_done_r;
  assign timeout_err     = timeout_err_r;

  assign tx_push_s = stream.tx_valid && !tx_full_s;
  assign rx_pop_s  = stream.rx_ready && !rx_empty_s;
  // RX space is reserved here: with one word in flight and RX only draining,
  // the later push cannot overflow. No launch in a flush cycle (pop ignored).
  assign launch_s  = (state_r == IDLE) && enable && !tx_empty_s && !rx_full_s
                     && !m_busy && !flush;
  assign rx_push_s = (state_r == WAIT_DONE) && m_done && !discard_r && !flush;
  assign timeout_s = (state_r == WAIT_DONE) && !m_done && (to_cnt_r == TO_LAST);

  spi_sync_fifo #(.DATA_WIDTH(DATA_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .rst_n(rst_n), .clear(flush), .push(tx_push_s), .pop(launch_s),
    .din(stream.tx_data), .dout(tx_dout_s), .full(tx_full_s), .empty(tx_empty_s),
    .level(tx_level)
  );

  spi_sync_fifo #(.DATA_WIDTH(DATA_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .rst_n(rst_n), .clear(flush), .push(rx_push_s), .pop(rx_pop_s),
    .din(m_rx_data), .dout(rx_dout_s), .full(rx_full_s), .empty(rx_empty_s),
    .level(rx_level)
  );

  // Next-state decode for the launch sequencer.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (launch_s) state_s = LAUNCH;
        else          state_s = IDLE;
      end
      LAUNCH: state_s = WAIT_DONE;
      WAIT_DONE: begin
        if (m_done || timeout_s) state_s = GAP;
        else                     state_s = WAIT_DONE;
      end
      GAP: begin
        if (gap_cnt_r == GAP_LAST) state_s = IDLE;
        else                       state_s = GAP;
      end
      default: state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= state_s;
  end

  // Timeout counter: zero in the LAUNCH cycle, so it hits TO_LAST exactly
  // TIMEOUT_CYCLES-1 cycles after m_start rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_r <= '0;
    end else if (launch_s) begin
      to_cnt_r <= '0;
    end else if (((state_r == LAUNCH) || (state_r == WAIT_DONE)) && (to_cnt_r != TO_LAST)) begin
      to_cnt_r <= to_cnt_r + TW'(1);
    end
  end

  // Gap counter: runs only while in GAP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gap_cnt_r <= '0;
    end else if ((state_r == GAP) && (gap_cnt_r != GAP_LAST)) begin
      gap_cnt_r <= gap_cnt_r + GW'(1);
    end else begin
      gap_cnt_r <= '0;
    end
  end

  // Discard bit: a flush while a word is in flight drops its result. The
  // LAUNCH cycle is included because that word is equally stale.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      discard_r <= 1'b0;
    end else if ((state_r == WAIT_DONE) && (state_s != WAIT_DONE)) begin
      discard_r <= 1'b0;
    end else if (flush && ((state_r == LAUNCH) || (state_r == WAIT_DONE))) begin
      discard_r <= 1'b1;
    end
  end

  // Registered master-side and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_start_r     <= 1'b0;
      m_tx_data_r   <= '0;
      word_done_r   <= 1'b0;
      timeout_err_r <= 1'b0;
    end else begin
      m_start_r   <= launch_s;
      word_done_r <= rx_push_s;
      if (launch_s) m_tx_data_r <= tx_dout_s;
      // A new abort outranks a simultaneous flush.
      if (timeout_s)  timeout_err_r <= 1'b1;
      else if (flush) timeout_err_r <= 1'b0;
    end
  end

endmodule
